// File: rtl/dcache_snoop_master_pkg.sv
// Shared types for the data-cache ACE snoop initiator: AC/CR/CD channel structs,
// snoop opcodes, FSM state encoding and the packed per-snoop result.
package dcache_snoop_master_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH  = 128;
  localparam int unsigned DCACHE_BYTE_OFFSET = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned BEATS_W            = 8;
  localparam logic [63:0] LINE_ADDR_MASK     = ~((64'd1 << DCACHE_BYTE_OFFSET) - 64'd1);

  // CR response bit positions
  localparam int unsigned CR_DATA      = 0;
  localparam int unsigned CR_ERR       = 1;
  localparam int unsigned CR_PASSDIRTY = 2;
  localparam int unsigned CR_ISSHARED  = 3;
  localparam int unsigned CR_WASUNIQUE = 4;

  typedef enum logic [3:0] {
    READ_ONCE             = 4'b0000,
    READ_SHARED           = 4'b0001,
    READ_CLEAN            = 4'b0010,
    READ_NOT_SHARED_DIRTY = 4'b0011,
    READ_UNIQUE           = 4'b0111,
    CLEAN_SHARED          = 4'b1000,
    CLEAN_INVALID         = 4'b1001,
    MAKE_INVALID          = 4'b1101,
    DVM_COMPLETE          = 4'b1110,
    DVM_MESSAGE           = 4'b1111
  } acsnoop_t;

  typedef struct packed {
    logic [63:0] addr;
    acsnoop_t    snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

  typedef enum logic [1:0] {IDLE, AC, RESP, DONE} snoop_master_state_e;

  typedef struct packed {
    logic [63:0]                  addr;
    acsnoop_t                     snoop;
    logic [4:0]                   cr_resp;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic [BEATS_W-1:0]           beats;
    logic                         error;
    logic                         timeout;
  } snoop_result_t;

endpackage

// File: rtl/snoop_cd_collector.sv
// CD beat collector: assembles beats into a line, counts them (saturating at a
// full line) and flags a misplaced last or an overrun.
module snoop_cd_collector import dcache_snoop_master_pkg::*; #(
  parameter int unsigned LINE_WIDTH = DCACHE_LINE_WIDTH,
  parameter int unsigned CD_WIDTH   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  beat_i,
  input  logic [CD_WIDTH-1:0]   cd_data_i,
  input  logic                  cd_last_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic [BEATS_W-1:0]    beats_o,
  output logic                  last_seen_o,
  output logic                  err_o
);
  localparam int unsigned        CD_BEATS = LINE_WIDTH / CD_WIDTH;
  localparam logic [BEATS_W-1:0] FULL     = BEATS_W'(CD_BEATS);

  logic [LINE_WIDTH-1:0] line_q;
  logic [BEATS_W-1:0]    cnt_q;
  logic                  last_q, err_q, full;

  assign full = (cnt_q == FULL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (clr_i) begin
      line_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (beat_i) begin
      if (cd_last_i) last_q <= 1'b1;
      // beats past a full line are dropped, but the overrun is remembered
      if (full || (cd_last_i && cnt_q != FULL - BEATS_W'(1))) err_q <= 1'b1;
      if (!full) begin
        cnt_q <= cnt_q + BEATS_W'(1);
        for (int k = 0; k < CD_BEATS; k++)
          if (cnt_q == BEATS_W'(k)) line_q[k*CD_WIDTH +: CD_WIDTH] <= cd_data_i;
      end
    end
  end

  assign line_o      = line_q;
  assign beats_o     = cnt_q;
  assign last_seen_o = last_q;
  assign err_o       = err_q;

endmodule

// File: rtl/dcache_snoop_master.sv
// ACE snoop initiator, one snoop in flight: issues AC, gathers CR and CD, returns
// a packed result. Define SNOOP_TIMEOUT_EN to enable the response watchdog.
module dcache_snoop_master import dcache_snoop_master_pkg::*; #(
  parameter int unsigned LINE_WIDTH     = DCACHE_LINE_WIDTH,
  parameter int unsigned CD_WIDTH       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [63:0]   cmd_addr_i,
  input  acsnoop_t      cmd_snoop_i,
  output snoop_req_t    snoop_req_o,
  input  snoop_resp_t   snoop_resp_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output snoop_result_t res_o
);
  snoop_master_state_e   state_q, state_d;
  logic [63:0]           addr_q;
  acsnoop_t              snoop_q;
  logic [4:0]            cr_q, cr_eff;
  logic                  cr_got_q, cmd_ready_q;
  logic                  accept, in_resp, beat, cr_hs, cr_have, last_have;
  logic                  to_fire, timeout_q, unexpected;
  logic [LINE_WIDTH-1:0] line;
  logic [BEATS_W-1:0]    beats;
  logic                  last_seen, col_err;

  assign accept    = (state_q == IDLE) && cmd_valid_i && cmd_ready_q;
  assign in_resp   = (state_q == RESP);
  assign beat      = in_resp && snoop_resp_i.cd_valid;
  assign cr_hs     = in_resp && snoop_resp_i.cr_valid && !cr_got_q;
  assign cr_have   = cr_got_q || cr_hs;
  assign cr_eff    = cr_got_q ? cr_q : snoop_resp_i.cr_resp;
  assign last_have = last_seen || (beat && snoop_resp_i.cd.last);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = AC;
      AC:   if (snoop_resp_i.ac_ready) state_d = RESP;
      RESP: if (cr_have && (!cr_eff[CR_DATA] || last_have)) state_d = DONE;
      DONE: if (res_ready_i) state_d = IDLE;
    endcase
    if (to_fire) state_d = DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      snoop_q     <= acsnoop_t'(4'b0000);
      cr_q        <= '0;
      cr_got_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      if (accept) begin
        addr_q   <= cmd_addr_i & LINE_ADDR_MASK;
        snoop_q  <= cmd_snoop_i;
        cr_q     <= '0;
        cr_got_q <= 1'b0;
      end else if (cr_hs) begin
        cr_q     <= snoop_resp_i.cr_resp;
        cr_got_q <= 1'b1;
      end
    end
  end

  snoop_cd_collector #(.LINE_WIDTH(LINE_WIDTH), .CD_WIDTH(CD_WIDTH)) u_collector (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (accept),
    .beat_i      (beat),
    .cd_data_i   (snoop_resp_i.cd.data),
    .cd_last_i   (snoop_resp_i.cd.last),
    .line_o      (line),
    .beats_o     (beats),
    .last_seen_o (last_seen),
    .err_o       (col_err)
  );

`ifdef SNOOP_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        busy;

  assign busy    = (state_q == AC) || in_resp;
  assign to_fire = busy && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q <= busy ? to_cnt_q + 32'd1 : '0;
      if (accept) timeout_q <= 1'b0;
      else if (to_fire) begin
        timeout_q <= 1'b1;
        $error("dcache_snoop_master: snoop to %h timed out", addr_q);
      end
    end
  end
`else
  assign to_fire   = 1'b0;
  assign timeout_q = 1'b0;
`endif

  // data beats on a snoop that answered without DataTransfer
  assign unexpected = cr_got_q && !cr_q[CR_DATA] && (beats != '0);

  always_comb begin
    snoop_req_o          = '0;
    snoop_req_o.ac_valid = (state_q == AC);
    snoop_req_o.ac.addr  = addr_q;
    snoop_req_o.ac.snoop = snoop_q;
    snoop_req_o.ac.prot  = 3'b000;
    snoop_req_o.cr_ready = in_resp;
    snoop_req_o.cd_ready = in_resp;
  end

  always_comb begin
    res_o         = '0;
    res_o.addr    = addr_q;
    res_o.snoop   = snoop_q;
    res_o.cr_resp = cr_q;
    res_o.data    = line;
    res_o.beats   = beats;
    res_o.error   = cr_q[CR_ERR] || unexpected || col_err || timeout_q;
    res_o.timeout = timeout_q;
  end

  assign cmd_ready_o = cmd_ready_q;
  assign res_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_dcache_snoop_master.sv
// Bench for dcache_snoop_master: directed scenarios plus randomized CR/CD
// orderings checked against a cycle-level reference model of the snoop rules.
module tb_dcache_snoop_master;
  import dcache_snoop_master_pkg::*;

  localparam int CDB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [63:0]   cmd_addr = '0;
  acsnoop_t      cmd_snoop = READ_ONCE;
  snoop_req_t    req;
  snoop_resp_t   resp = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  snoop_result_t res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_snoop_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_snoop_i  (cmd_snoop),
    .snoop_req_o  (req),
    .snoop_resp_i (resp),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_o        (res)
  );

  // scenario: beat i presented on RESP cycle sc_t[i]; CR presented on cycle sc_cr_t
  int           sc_n;
  int           sc_t[8];
  logic [63:0]  sc_d[8];
  logic         sc_last[8];
  int           sc_cr_t;
  logic [4:0]   sc_cr;

  // observations from the driver
  int            ob_ac_lat, ob_done_t;
  logic [63:0]   ob_ac_addr;
  acsnoop_t      ob_ac_snoop;
  logic [2:0]    ob_ac_prot;
  logic          ob_ac_moved, ob_hold_bad, ob_rdy_t0, ob_cmd_ready_after, ob_res_valid_after;
  snoop_result_t ob_res;
  logic          ob_rst_cmd_ready, ob_rst_res_valid;
  snoop_req_t    ob_rst_req;
  snoop_result_t ob_rst_res;

  snoop_result_t exp_res;
  int            exp_t;

  // Reference: walk RESP cycles to find completion, then fold the accepted beats.
  function automatic void model(input logic [63:0] a, input acsnoop_t s);
    int t_done, acc;
    bit got_cr, got_last, err;
    logic [DCACHE_LINE_WIDTH-1:0] line;
    t_done = -1; got_cr = 0; got_last = 0;
    for (int t = 0; t < 64 && t_done < 0; t++) begin
      if (t == sc_cr_t) got_cr = 1;
      for (int i = 0; i < sc_n; i++) if (sc_t[i] == t && sc_last[i]) got_last = 1;
      if (got_cr && (!sc_cr[0] || got_last)) t_done = t;
    end
    exp_t = t_done + 1;
    err = sc_cr[1]; acc = 0; line = '0;
    for (int i = 0; i < sc_n; i++) begin
      if (sc_t[i] <= t_done) begin
        if (acc < CDB) line[acc*64 +: 64] = sc_d[i];
        if (!sc_cr[0]) err = 1;
        if (acc >= CDB) err = 1;
        if (sc_last[i] && acc + 1 != CDB) err = 1;
        acc++;
      end
    end
    exp_res = '0;
    exp_res.addr    = a & ~64'hF;
    exp_res.snoop   = s;
    exp_res.cr_resp = sc_cr;
    exp_res.data    = line;
    exp_res.beats   = 8'((acc > CDB) ? CDB : acc);
    exp_res.error   = err;
  endfunction

  task automatic run_snoop(input logic [63:0] a, input acsnoop_t s, input int ac_delay,
                           input int hold, input int abort_t);
    int w;
    ob_ac_lat = -1; ob_done_t = -1; ob_ac_moved = 0; ob_hold_bad = 0;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    cmd_valid = 1; cmd_addr = a; cmd_snoop = s;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = {$urandom, $urandom}; cmd_snoop = READ_UNIQUE;
    w = 1;
    while (!req.ac_valid && w < 10) begin @(negedge clk); w++; end
    if (req.ac_valid) ob_ac_lat = w;
    ob_ac_addr = req.ac.addr; ob_ac_snoop = req.ac.snoop; ob_ac_prot = req.ac.prot;
    for (int i = 0; i < ac_delay; i++) begin
      @(negedge clk);
      if (!req.ac_valid || req.ac.addr !== ob_ac_addr || req.ac.snoop !== ob_ac_snoop) ob_ac_moved = 1;
    end
    resp.ac_ready = 1;
    @(negedge clk);
    resp.ac_ready = 0;
    ob_rdy_t0 = req.cr_ready & req.cd_ready;
    for (int t = 0; t < 64; t++) begin
      if (res_valid) begin ob_done_t = t; break; end
      if (t == abort_t) begin
        resp.cr_valid = 0; resp.cd_valid = 0;
        #2 rst_n = 0;
        #1;
        ob_rst_cmd_ready = cmd_ready; ob_rst_req = req;
        ob_rst_res_valid = res_valid; ob_rst_res = res;
        return;
      end
      resp.cr_valid = (t == sc_cr_t);
      resp.cr_resp  = (t == sc_cr_t) ? sc_cr : 5'($urandom);
      resp.cd_valid = 0;
      resp.cd.data  = {$urandom, $urandom};
      resp.cd.last  = 0;
      for (int i = 0; i < sc_n; i++)
        if (sc_t[i] == t) begin resp.cd_valid = 1; resp.cd.data = sc_d[i]; resp.cd.last = sc_last[i]; end
      @(negedge clk);
    end
    resp.cr_valid = 0; resp.cd_valid = 0;
    ob_res = res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res !== ob_res || !res_valid || cmd_ready || req.ac_valid) ob_hold_bad = 1;
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    ob_cmd_ready_after = cmd_ready; ob_res_valid_after = res_valid;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (req !== '0) begin failures++; $display("FAIL reset_snoop_req: got %h want 0", req); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res !== '0) begin failures++; $display("FAIL reset_res: got %h want 0", res); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_read_shared_hit;
    sc_n = 2; sc_cr = 5'b01001; sc_cr_t = 0;
    sc_t[0] = 1; sc_d[0] = 64'h1111_1111_1111_1111; sc_last[0] = 0;
    sc_t[1] = 2; sc_d[1] = 64'h2222_2222_2222_2222; sc_last[1] = 1;
    model(64'h8000_0040, READ_SHARED);
    run_snoop(64'h8000_0040, READ_SHARED, 2, 0, -1);
    checks++; if (ob_ac_lat !== 1) begin failures++; $display("FAIL rs_ac_latency: got %0d want 1", ob_ac_lat); end
    checks++; if (ob_ac_addr !== 64'h8000_0040 || ob_ac_snoop !== READ_SHARED || ob_ac_prot !== 3'b000) begin
      failures++; $display("FAIL rs_ac_payload: got %h/%h/%h want 8000_0040/%h/0", ob_ac_addr, ob_ac_snoop, ob_ac_prot, READ_SHARED); end
    checks++; if (ob_ac_moved !== 1'b0) begin failures++; $display("FAIL rs_ac_stable: got moved=%b want 0", ob_ac_moved); end
    checks++; if (ob_rdy_t0 !== 1'b1) begin failures++; $display("FAIL rs_resp_ready: got %b want 1", ob_rdy_t0); end
    checks++; if (ob_done_t !== 3) begin failures++; $display("FAIL rs_done_cycle: got %0d want 3", ob_done_t); end
    checks++; if (ob_res.data !== {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111} || ob_res.beats !== 8'd2 || ob_res.error !== 1'b0) begin
      failures++; $display("FAIL rs_line: got %h beats=%0d err=%b want 2222..1111 beats=2 err=0", ob_res.data, ob_res.beats, ob_res.error); end
    checks++; if (ob_res !== exp_res) begin failures++; $display("FAIL rs_result: got %h want %h", ob_res, exp_res); end
  endtask

  task automatic test_clean_invalid_miss;
    sc_n = 0; sc_cr = 5'b00000; sc_cr_t = 1;
    model(64'h8000_1000, CLEAN_INVALID);
    run_snoop(64'h8000_1000, CLEAN_INVALID, 0, 0, -1);
    checks++; if (ob_done_t !== 2) begin failures++; $display("FAIL ci_done_cycle: got %0d want 2", ob_done_t); end
    checks++; if (ob_res.beats !== 8'd0 || ob_res.error !== 1'b0 || ob_res.data !== '0) begin
      failures++; $display("FAIL ci_fields: got beats=%0d err=%b data=%h want 0/0/0", ob_res.beats, ob_res.error, ob_res.data); end
    checks++; if (ob_res !== exp_res) begin failures++; $display("FAIL ci_result: got %h want %h", ob_res, exp_res); end
  endtask

  task automatic test_cd_before_cr;
    sc_n = 2; sc_cr = 5'b00001; sc_cr_t = 4;
    sc_t[0] = 0; sc_d[0] = {$urandom, $urandom}; sc_last[0] = 0;
    sc_t[1] = 1; sc_d[1] = {$urandom, $urandom}; sc_last[1] = 1;
    model(64'h8000_2080, READ_UNIQUE);
    run_snoop(64'h8000_2080, READ_UNIQUE, 0, 0, -1);
    checks++; if (ob_done_t !== 5) begin failures++; $display("FAIL early_cd_done_cycle: got %0d want 5", ob_done_t); end
    checks++; if (ob_res.data !== {sc_d[1], sc_d[0]} || ob_res.beats !== 8'd2 || ob_res.error !== 1'b0) begin
      failures++; $display("FAIL early_cd_line: got %h beats=%0d err=%b want %h%h", ob_res.data, ob_res.beats, ob_res.error, sc_d[1], sc_d[0]); end
    checks++; if (ob_res !== exp_res) begin failures++; $display("FAIL early_cd_result: got %h want %h", ob_res, exp_res); end
  endtask

  task automatic test_res_hold;
    logic [63:0] a;
    a = {$urandom, $urandom};
    sc_n = 2; sc_cr = 5'b00101; sc_cr_t = 1;
    sc_t[0] = 0; sc_d[0] = {$urandom, $urandom}; sc_last[0] = 0;
    sc_t[1] = 2; sc_d[1] = {$urandom, $urandom}; sc_last[1] = 1;
    model(a, READ_CLEAN);
    run_snoop(a, READ_CLEAN, 1, 5, -1);
    checks++; if (ob_ac_addr !== (a & ~64'hF)) begin failures++; $display("FAIL hold_ac_addr_mask: got %h want %h", ob_ac_addr, a & ~64'hF); end
    checks++; if (ob_hold_bad !== 1'b0) begin failures++; $display("FAIL hold_stable: got disturbed=%b want 0", ob_hold_bad); end
    checks++; if (ob_cmd_ready_after !== 1'b1 || ob_res_valid_after !== 1'b0) begin
      failures++; $display("FAIL hold_release: got cmd_ready=%b res_valid=%b want 1/0", ob_cmd_ready_after, ob_res_valid_after); end
    checks++; if (ob_res !== exp_res) begin failures++; $display("FAIL hold_result: got %h want %h", ob_res, exp_res); end
  endtask

  task automatic test_reset_mid;
    sc_n = 2; sc_cr = 5'b00001; sc_cr_t = 3;
    sc_t[0] = 0; sc_d[0] = {$urandom, $urandom}; sc_last[0] = 0;
    sc_t[1] = 1; sc_d[1] = {$urandom, $urandom}; sc_last[1] = 1;
    run_snoop(64'h8000_3000, READ_SHARED, 0, 0, 1);
    checks++; if (ob_rst_cmd_ready !== 1'b0 || ob_rst_res_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl: got cmd_ready=%b res_valid=%b want 0/0", ob_rst_cmd_ready, ob_rst_res_valid); end
    checks++; if (ob_rst_req !== '0 || ob_rst_res !== '0) begin
      failures++; $display("FAIL midrst_outputs: got req=%h res=%h want 0/0", ob_rst_req, ob_rst_res); end
    resp = '0;
    @(negedge clk);
    rst_n = 1;
    sc_n = 2; sc_cr = 5'b00001; sc_cr_t = 1;
    sc_t[0] = 0; sc_d[0] = {$urandom, $urandom}; sc_last[0] = 0;
    sc_t[1] = 2; sc_d[1] = {$urandom, $urandom}; sc_last[1] = 1;
    model(64'h8000_3000, READ_SHARED);
    run_snoop(64'h8000_3000, READ_SHARED, 0, 0, -1);
    checks++; if (ob_res.beats !== 8'd2 || ob_done_t !== 3) begin
      failures++; $display("FAIL midrst_resume: got beats=%0d done=%0d want 2/3", ob_res.beats, ob_done_t); end
    checks++; if (ob_res !== exp_res) begin failures++; $display("FAIL midrst_result: got %h want %h", ob_res, exp_res); end
  endtask

  task automatic test_random;
    logic [63:0] a;
    acsnoop_t    s;
    int          t;
    for (int it = 0; it < 30; it++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: s = READ_ONCE;
        1: s = READ_SHARED;
        2: s = CLEAN_INVALID;
        default: s = MAKE_INVALID;
      endcase
      sc_cr = 5'($urandom);
      sc_cr_t = $urandom_range(0, 6);
      sc_n = $urandom_range(0, 3);
      t = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        sc_t[i] = t; t += $urandom_range(1, 2);
        sc_d[i] = {$urandom, $urandom};
        sc_last[i] = (i == sc_n - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      end
      if (sc_cr[0]) begin
        if (sc_n == 0) sc_n = 1;
        sc_last[sc_n-1] = 1;
      end
      model(a, s);
      run_snoop(a, s, $urandom_range(0, 3), 0, -1);
      checks++; if (ob_done_t !== exp_t) begin failures++; $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", it, ob_done_t, exp_t); end
      checks++; if (ob_res !== exp_res) begin failures++; $display("FAIL rand_result[%0d]: got %h want %h", it, ob_res, exp_res); end
    end
  endtask

`ifdef SNOOP_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    cmd_valid = 1; cmd_addr = 64'h8000_4000; cmd_snoop = READ_ONCE;
    @(negedge clk);
    cmd_valid = 0;
    k = 0;
    while (!res_valid && k < 100) begin @(negedge clk); k++; end
    checks++; if (k !== 16) begin failures++; $display("FAIL timeout_cycles: got %0d want 16", k); end
    checks++; if (res.timeout !== 1'b1 || res.error !== 1'b1) begin
      failures++; $display("FAIL timeout_flags: got timeout=%b err=%b want 1/1", res.timeout, res.error); end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_shared_hit();
    test_clean_invalid_miss();
    test_cd_before_cr();
    test_res_hold();
    test_reset_mid();
    test_random();
`ifdef SNOOP_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
